ysyx_24110015_axi_arb: RTL
==========================

YSYX_24110015_AXI_ARB -- requirements
Module: ysyx_24110015_axi_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all AR/AW channels.
REQ-002 SHALL have parameter DATA_W, default 32, data width of R/W channels; WSTRB width DATA_W/8.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ifu, axi_lite_if.slave, bundle, instruction-fetch requester; read-only use.
REQ-006 SHALL have port lsu, axi_lite_if.slave, bundle, load/store requester; read and write.
REQ-007 SHALL have port mem, axi_lite_if.master, bundle, single shared downstream AXI-lite port.

Function
REQ-008 SHALL implement FSM states IDLE, IFU_RD, LSU_RD, LSU_WR.
REQ-009 In IDLE, all mem valids SHALL be 0 and all requester readies/valids SHALL be 0.
REQ-010 In IDLE, a pending lsu.awvalid SHALL select LSU_WR on the next edge.
REQ-011 In IDLE, a pending lsu.arvalid with no lsu.awvalid SHALL select LSU_RD on the next edge.
REQ-012 In IDLE, ifu.arvalid SHALL select IFU_RD only if no LSU request is pending (fixed priority, LSU > IFU).
REQ-013 Grant latency SHALL be exactly 1 cycle: request seen in IDLE at cycle N, forwarded to mem at cycle N+1.
REQ-014 In IFU_RD/LSU_RD, the granted AR and R channels SHALL be connected combinationally to mem (araddr, arsize, arvalid/arready, rdata, rresp, rvalid/rready).
REQ-015 In LSU_WR, lsu AW, W and B channels (awaddr, awsize, wdata, wstrb, wlast, valids/readies, bresp) SHALL be connected combinationally to mem.
REQ-016 The non-granted requester SHALL see arready=awready=wready=0, rvalid=bvalid=0, rdata=0.
REQ-017 Grant SHALL be held from entry until the response handshake (rvalid&rready for reads, bvalid&bready for writes), then return to IDLE on that edge.
REQ-018 Back-to-back transactions SHALL therefore have at least one IDLE cycle between a response handshake and the next forwarded address.
REQ-019 Write channels of ifu SHALL be permanently tied off: awready=wready=bvalid=0.
REQ-020 Requester valids dropping before their handshake SHALL NOT change the grant; the FSM waits for the response.
REQ-021 Error responses (rresp/bresp != 0) SHALL be passed through unchanged and release the grant identically.

Reset
REQ-022 rst SHALL force state IDLE and the last-grant register to IFU, asynchronously.
REQ-023 During and after reset, all mem valids and all requester readies/valids SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon the transaction without generating any response to either requester.

Configuration
REQ-025 With macro YSYX_24110015_ARB_RR_EN defined, IDLE arbitration SHALL be round-robin: when both IFU and LSU request, the one not granted last SHALL win; last-grant SHALL update on each grant.
REQ-026 Without YSYX_24110015_ARB_RR_EN, fixed priority per REQ-010..012 SHALL apply and no last-grant register SHALL exist.

Structure
REQ-027 The state enum (arb_state_t) and grant-owner enum SHALL live in shared package ysyx_24110015_pkg.
REQ-028 A sub-module ysyx_24110015_arb_pick (combinational owner selection, fixed or round-robin) SHALL be used; channel muxing stays in the top.

Verification
REQ-029 Reset: assert rst mid LSU_WR -> all valids/readies 0 same cycle, state IDLE, no bvalid to lsu.
REQ-030 Lone IFU read 0x80000000: ifu.arvalid at cycle N -> mem.arvalid=1, mem.araddr=0x80000000 at N+1; rdata 0x00000413 returned to ifu, lsu sees rvalid=0.
REQ-031 Simultaneous ifu.arvalid and lsu.arvalid (fixed mode) -> LSU_RD first; IFU granted one IDLE cycle after LSU R handshake.
REQ-032 Same as REQ-031 with YSYX_24110015_ARB_RR_EN, last grant LSU -> IFU_RD first.
REQ-033 LSU store to 0x0f000004, wdata 0x12345678, wstrb 0xF -> mem AW/W carry those values; bresp=2'b10 forwarded to lsu, state IDLE next cycle.
REQ-034 mem.arready held 0 for 5 cycles during IFU_RD while lsu.awvalid=1 -> grant remains IFU, lsu.awready=0 throughout.

Source files
------------

// File: rtl/ysyx_24110015_pkg.sv
// Shared types for the AXI-lite arbiter: FSM states, grant owners and channel widths.
package ysyx_24110015_pkg;

    localparam int AXI_SIZE_W = 3;
    localparam int AXI_RESP_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // Which requester a granted state belongs to.
    function automatic owner_t owner_of(input arb_state_t s);
        return (s == IFU_RD) ? OWN_IFU : OWN_LSU;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle. The master modport issues addresses/data; the slave modport answers.
//
// Handshake rule on every channel: a beat transfers on a rising clk edge where
// valid and ready are both 1; valid is raised by the sender, ready by the receiver.
interface axi_lite_if
    import ysyx_24110015_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]     araddr;
    logic [AXI_SIZE_W-1:0] arsize;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     rdata;
    logic [AXI_RESP_W-1:0] rresp;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_W-1:0]     awaddr;
    logic [AXI_SIZE_W-1:0] awsize;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [AXI_RESP_W-1:0] bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arsize, arvalid, rready,
        output awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arsize, arvalid, rready,
        input  awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_24110015_arb_pick.sv
// Combinational owner selection used while the arbiter is idle.
// LSU beats IFU; a pending LSU write beats a pending LSU read.
// With YSYX_24110015_ARB_RR_EN the IFU wins a tie when the LSU was granted last.
module ysyx_24110015_arb_pick
    import ysyx_24110015_pkg::*;
(
    input  logic       ifu_rd,
    input  logic       lsu_rd,
    input  logic       lsu_wr,
`ifdef YSYX_24110015_ARB_RR_EN
    input  owner_t     last,
`endif
    output arb_state_t pick
);

    // Choose the state to enter from IDLE given the current requests.
    always_comb begin
        pick = IDLE;
        if (lsu_wr) begin
            pick = LSU_WR;
        end else if (lsu_rd) begin
            pick = LSU_RD;
        end else if (ifu_rd) begin
            pick = IFU_RD;
        end
`ifdef YSYX_24110015_ARB_RR_EN
        if (ifu_rd && (lsu_wr || lsu_rd) && (last == OWN_LSU)) begin
            pick = IFU_RD;
        end
`endif
    end

endmodule

// File: rtl/ysyx_24110015_axi_arb.sv
// Two-requester AXI-lite arbiter: IFU (read only) and LSU (read/write) share one mem port.
// A grant is held from entry until the response handshake, then the FSM returns to IDLE.
// Optional macro YSYX_24110015_ARB_RR_EN switches IDLE arbitration to round-robin.
module ysyx_24110015_axi_arb
    import ysyx_24110015_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    axi_lite_if.slave  ifu,
    axi_lite_if.slave  lsu,
    axi_lite_if.master mem,
    output arb_state_t dbg_state
);

    arb_state_t state;
    arb_state_t state_d;
    arb_state_t pick;

`ifdef YSYX_24110015_ARB_RR_EN
    owner_t last_q;

    // Remember who won the most recent grant so a tie goes to the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWN_IFU;
        end else if ((state == IDLE) && (pick != IDLE)) begin
            last_q <= owner_of(pick);
        end
    end
`endif

    ysyx_24110015_arb_pick u_pick (
        .ifu_rd (ifu.arvalid),
        .lsu_rd (lsu.arvalid),
        .lsu_wr (lsu.awvalid),
`ifdef YSYX_24110015_ARB_RR_EN
        .last   (last_q),
`endif
        .pick   (pick)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state: grant from IDLE, release on the response handshake only.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:           state_d = pick;
            IFU_RD, LSU_RD: if (mem.rvalid && mem.rready) state_d = IDLE;
            LSU_WR:         if (mem.bvalid && mem.bready) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // Channel muxing: only the granted channels are connected, everything else is quiet.
    always_comb begin
        mem.araddr  = {ADDR_W{1'b0}};
        mem.arsize  = '0;
        mem.arvalid = 1'b0;
        mem.rready  = 1'b0;
        mem.awaddr  = {ADDR_W{1'b0}};
        mem.awsize  = '0;
        mem.awvalid = 1'b0;
        mem.wdata   = {DATA_W{1'b0}};
        mem.wstrb   = '0;
        mem.wlast   = 1'b0;
        mem.wvalid  = 1'b0;
        mem.bready  = 1'b0;

        ifu.arready = 1'b0;
        ifu.rdata   = {DATA_W{1'b0}};
        ifu.rresp   = '0;
        ifu.rvalid  = 1'b0;
        ifu.awready = 1'b0;
        ifu.wready  = 1'b0;
        ifu.bresp   = '0;
        ifu.bvalid  = 1'b0;

        lsu.arready = 1'b0;
        lsu.rdata   = {DATA_W{1'b0}};
        lsu.rresp   = '0;
        lsu.rvalid  = 1'b0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bresp   = '0;
        lsu.bvalid  = 1'b0;

        case (state)
            IFU_RD: begin
                mem.araddr  = ifu.araddr;
                mem.arsize  = ifu.arsize;
                mem.arvalid = ifu.arvalid;
                ifu.arready = mem.arready;
                ifu.rdata   = mem.rdata;
                ifu.rresp   = mem.rresp;
                ifu.rvalid  = mem.rvalid;
                mem.rready  = ifu.rready;
            end
            LSU_RD: begin
                mem.araddr  = lsu.araddr;
                mem.arsize  = lsu.arsize;
                mem.arvalid = lsu.arvalid;
                lsu.arready = mem.arready;
                lsu.rdata   = mem.rdata;
                lsu.rresp   = mem.rresp;
                lsu.rvalid  = mem.rvalid;
                mem.rready  = lsu.rready;
            end
            LSU_WR: begin
                mem.awaddr  = lsu.awaddr;
                mem.awsize  = lsu.awsize;
                mem.awvalid = lsu.awvalid;
                lsu.awready = mem.awready;
                mem.wdata   = lsu.wdata;
                mem.wstrb   = lsu.wstrb;
                mem.wlast   = lsu.wlast;
                mem.wvalid  = lsu.wvalid;
                lsu.wready  = mem.wready;
                lsu.bresp   = mem.bresp;
                lsu.bvalid  = mem.bvalid;
                mem.bready  = lsu.bready;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule
